// File: rtl/id_ex_stage_reg.sv
// ID/EX pipeline register with load-use hazard detection and bubble insertion.
// Define ID_EX_STALL_CNT_EN to build the saturating load-use stall counter.
module id_ex_stage_reg #(
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              id_valid,
    input  logic [4:0]        id_rs,
    input  logic [4:0]        id_rt,
    input  logic [4:0]        id_rd,
    input  logic [DATA_W-1:0] id_rs_data,
    input  logic [DATA_W-1:0] id_rt_data,
    input  logic [DATA_W-1:0] id_imm,
    input  logic              id_reg_write,
    input  logic              id_mem_read,
    input  logic              id_mem_write,
    input  logic              id_mem_to_reg,
    input  logic              id_alu_src,
    input  logic              id_reg_dst,
    input  logic [3:0]        id_alu_op,
    input  logic              id_uses_rt,
    input  logic              flush,

    output logic              stall,
    output logic              ex_valid,
    output logic [4:0]        ID_EX_RegisterRs,
    output logic [4:0]        ID_EX_RegisterRt,
    output logic [4:0]        ex_dest,
    output logic [DATA_W-1:0] ex_rs_data,
    output logic [DATA_W-1:0] ex_rt_data,
    output logic [DATA_W-1:0] ex_imm,
    output logic              ex_reg_write,
    output logic              ex_mem_read,
    output logic              ex_mem_write,
    output logic              ex_mem_to_reg,
    output logic              ex_alu_src,
    output logic [3:0]        ex_alu_op,
    output logic [31:0]       stall_count
);

    logic              validQ;
    logic [4:0]        rsQ, rtQ, destQ;
    logic [DATA_W-1:0] rsDataQ, rtDataQ, immQ;
    logic              regWriteQ, memReadQ, memWriteQ, memToRegQ, aluSrcQ;
    logic [3:0]        aluOpQ;

    logic hazard;
    logic bubble;

    // Register 0 is hardwired, so a load targeting it never creates a dependency.
    always_comb begin
        hazard = validQ && memReadQ && (destQ != 5'd0) && id_valid &&
                 ((destQ == id_rs) || (id_uses_rt && (destQ == id_rt)));
    end

    assign stall  = hazard && !flush;
    assign bubble = flush || stall || !id_valid;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            validQ    <= 1'b0;
            rsQ       <= '0;
            rtQ       <= '0;
            destQ     <= '0;
            rsDataQ   <= '0;
            rtDataQ   <= '0;
            immQ      <= '0;
            regWriteQ <= 1'b0;
            memReadQ  <= 1'b0;
            memWriteQ <= 1'b0;
            memToRegQ <= 1'b0;
            aluSrcQ   <= 1'b0;
            aluOpQ    <= '0;
        end else if (bubble) begin
            validQ    <= 1'b0;
            rsQ       <= '0;
            rtQ       <= '0;
            destQ     <= '0;
            rsDataQ   <= '0;
            rtDataQ   <= '0;
            immQ      <= '0;
            regWriteQ <= 1'b0;
            memReadQ  <= 1'b0;
            memWriteQ <= 1'b0;
            memToRegQ <= 1'b0;
            aluSrcQ   <= 1'b0;
            aluOpQ    <= '0;
        end else begin
            validQ    <= 1'b1;
            rsQ       <= id_rs;
            rtQ       <= id_rt;
            destQ     <= id_reg_dst ? id_rd : id_rt;
            rsDataQ   <= id_rs_data;
            rtDataQ   <= id_rt_data;
            immQ      <= id_imm;
            regWriteQ <= id_reg_write;
            memReadQ  <= id_mem_read;
            memWriteQ <= id_mem_write;
            memToRegQ <= id_mem_to_reg;
            aluSrcQ   <= id_alu_src;
            aluOpQ    <= id_alu_op;
        end
    end

    assign ex_valid         = validQ;
    assign ID_EX_RegisterRs = rsQ;
    assign ID_EX_RegisterRt = rtQ;
    assign ex_dest          = destQ;
    assign ex_rs_data       = rsDataQ;
    assign ex_rt_data       = rtDataQ;
    assign ex_imm           = immQ;
    // State-changing controls are qualified so a bubble can never write.
    assign ex_reg_write     = validQ && regWriteQ;
    assign ex_mem_read      = validQ && memReadQ;
    assign ex_mem_write     = validQ && memWriteQ;
    assign ex_mem_to_reg    = memToRegQ;
    assign ex_alu_src       = aluSrcQ;
    assign ex_alu_op        = aluOpQ;

`ifdef ID_EX_STALL_CNT_EN
    logic [31:0] stallCountQ;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stallCountQ <= '0;
        end else if (stall && (stallCountQ != 32'hFFFF_FFFF)) begin
            stallCountQ <= stallCountQ + 32'd1;
        end
    end

    assign stall_count = stallCountQ;
`else
    assign stall_count = '0;
`endif

endmodule

// File: tb/tb_id_ex_stage_reg.sv
// Directed self-checking bench for id_ex_stage_reg: load-use stalls, flush, r0, reset.
module tb_id_ex_stage_reg;

    localparam int unsigned DATA_W = 32;

    logic              clk = 1'b0;
    logic              rst;
    logic              id_valid;
    logic [4:0]        id_rs, id_rt, id_rd;
    logic [DATA_W-1:0] id_rs_data, id_rt_data, id_imm;
    logic              id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg;
    logic              id_alu_src, id_reg_dst, id_uses_rt, flush;
    logic [3:0]        id_alu_op;

    logic              stall, ex_valid;
    logic [4:0]        ID_EX_RegisterRs, ID_EX_RegisterRt, ex_dest;
    logic [DATA_W-1:0] ex_rs_data, ex_rt_data, ex_imm;
    logic              ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_alu_src;
    logic [3:0]        ex_alu_op;
    logic [31:0]       stall_count;

    int checks = 0;
    int errors = 0;

`ifdef ID_EX_STALL_CNT_EN
    localparam bit CntEn = 1'b1;
`else
    localparam bit CntEn = 1'b0;
`endif

    id_ex_stage_reg #(.DATA_W(DATA_W)) dut (
        .clk              (clk),
        .rst              (rst),
        .id_valid         (id_valid),
        .id_rs            (id_rs),
        .id_rt            (id_rt),
        .id_rd            (id_rd),
        .id_rs_data       (id_rs_data),
        .id_rt_data       (id_rt_data),
        .id_imm           (id_imm),
        .id_reg_write     (id_reg_write),
        .id_mem_read      (id_mem_read),
        .id_mem_write     (id_mem_write),
        .id_mem_to_reg    (id_mem_to_reg),
        .id_alu_src       (id_alu_src),
        .id_reg_dst       (id_reg_dst),
        .id_alu_op        (id_alu_op),
        .id_uses_rt       (id_uses_rt),
        .flush            (flush),
        .stall            (stall),
        .ex_valid         (ex_valid),
        .ID_EX_RegisterRs (ID_EX_RegisterRs),
        .ID_EX_RegisterRt (ID_EX_RegisterRt),
        .ex_dest          (ex_dest),
        .ex_rs_data       (ex_rs_data),
        .ex_rt_data       (ex_rt_data),
        .ex_imm           (ex_imm),
        .ex_reg_write     (ex_reg_write),
        .ex_mem_read      (ex_mem_read),
        .ex_mem_write     (ex_mem_write),
        .ex_mem_to_reg    (ex_mem_to_reg),
        .ex_alu_src       (ex_alu_src),
        .ex_alu_op        (ex_alu_op),
        .stall_count      (stall_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Fields: valid rs rt rd regDst usesRt memRead memWrite regWrite memToReg aluSrc aluOp data.
    task automatic setId(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                         input logic [4:0] rd, input logic rdst, input logic urt,
                         input logic mr, input logic mw, input logic rw, input logic m2r,
                         input logic asrc, input logic [3:0] op, input logic [31:0] rsd,
                         input logic [31:0] rtd, input logic [31:0] imm);
        id_valid = v;      id_rs = rs;         id_rt = rt;        id_rd = rd;
        id_reg_dst = rdst; id_uses_rt = urt;   id_mem_read = mr;  id_mem_write = mw;
        id_reg_write = rw; id_mem_to_reg = m2r; id_alu_src = asrc; id_alu_op = op;
        id_rs_data = rsd;  id_rt_data = rtd;   id_imm = imm;
    endtask

    task automatic loadR8();
        setId(1'b1, 5'd1, 5'd8, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 4'h0,
              32'h100, 32'h0, 32'h4);
        tick();
    endtask

    task automatic addFromR8();
        setId(1'b1, 5'd8, 5'd9, 5'd10, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'h2,
              32'hAAAA, 32'hBBBB, 32'h0);
    endtask

    initial begin
        rst = 1'b1;
        flush = 1'b0;
        setId(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0,
              32'h0, 32'h0, 32'h0);
        #12;
        check("reset ex_valid", {31'd0, ex_valid}, 32'd0);
        check("reset ex_dest", {27'd0, ex_dest}, 32'd0);
        check("reset stall", {31'd0, stall}, 32'd0);
        check("reset stall_count", stall_count, 32'd0);
        rst = 1'b0;

        // lw r8 then dependent add: one-cycle stall, bubble, then add advances.
        loadR8();
        check("lw ex_valid", {31'd0, ex_valid}, 32'd1);
        check("lw ex_mem_read", {31'd0, ex_mem_read}, 32'd1);
        check("lw ex_dest", {27'd0, ex_dest}, 32'd8);
        check("lw ex_rs_data", ex_rs_data, 32'h100);
        check("lw ex_imm", ex_imm, 32'h4);
        check("lw ex_mem_to_reg", {31'd0, ex_mem_to_reg}, 32'd1);
        addFromR8();
        #1;
        check("loaduse stall", {31'd0, stall}, 32'd1);
        tick();
        check("loaduse bubble valid", {31'd0, ex_valid}, 32'd0);
        check("loaduse bubble dest", {27'd0, ex_dest}, 32'd0);
        check("loaduse bubble rs_data", ex_rs_data, 32'd0);
        check("loaduse bubble reg_write", {31'd0, ex_reg_write}, 32'd0);
        check("loaduse stall cleared", {31'd0, stall}, 32'd0);
        tick();
        check("add ex_valid", {31'd0, ex_valid}, 32'd1);
        check("add Rs", {27'd0, ID_EX_RegisterRs}, 32'd8);
        check("add Rt", {27'd0, ID_EX_RegisterRt}, 32'd9);
        check("add ex_dest", {27'd0, ex_dest}, 32'd10);
        check("add ex_alu_op", {28'd0, ex_alu_op}, 32'd2);
        check("add ex_rt_data", ex_rt_data, 32'hBBBB);
        check("add ex_reg_write", {31'd0, ex_reg_write}, 32'd1);
        check("add ex_mem_read", {31'd0, ex_mem_read}, 32'd0);

        // Flush overrides the hazard and produces a bubble.
        loadR8();
        addFromR8();
        flush = 1'b1;
        #1;
        check("flush stall", {31'd0, stall}, 32'd0);
        tick();
        check("flush ex_valid", {31'd0, ex_valid}, 32'd0);
        check("flush ex_reg_write", {31'd0, ex_reg_write}, 32'd0);
        flush = 1'b0;

        // Load to r0 never stalls.
        setId(1'b1, 5'd1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 4'h0,
              32'h0, 32'h0, 32'h0);
        tick();
        setId(1'b1, 5'd0, 5'd0, 5'd3, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'h1,
              32'h0, 32'h0, 32'h0);
        #1;
        check("r0 stall", {31'd0, stall}, 32'd0);
        tick();
        check("r0 ex_valid", {31'd0, ex_valid}, 32'd1);
        check("r0 ex_dest", {27'd0, ex_dest}, 32'd3);

        // rt match only stalls when rt is actually a source.
        loadR8();
        setId(1'b1, 5'd1, 5'd8, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 4'h0,
              32'h1, 32'h55, 32'h8);
        #1;
        check("rt unused stall", {31'd0, stall}, 32'd0);
        id_uses_rt = 1'b1;
        #1;
        check("rt used stall", {31'd0, stall}, 32'd1);
        tick();
        check("sw bubble valid", {31'd0, ex_valid}, 32'd0);
        tick();
        check("sw ex_mem_write", {31'd0, ex_mem_write}, 32'd1);
        check("sw ex_reg_write", {31'd0, ex_reg_write}, 32'd0);
        check("sw ex_rt_data", ex_rt_data, 32'h55);

        // Invalid ID becomes a bubble even with controls set.
        setId(1'b0, 5'd2, 5'd4, 5'd6, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'h3,
              32'h7, 32'h7, 32'h7);
        tick();
        check("invalid ex_valid", {31'd0, ex_valid}, 32'd0);
        check("invalid ex_mem_write", {31'd0, ex_mem_write}, 32'd0);
        check("stall_count two", stall_count, CntEn ? 32'd2 : 32'd0);

        // Reset mid-stall clears everything and discards the pending capture.
        loadR8();
        addFromR8();
        #1;
        check("pre-reset stall", {31'd0, stall}, 32'd1);
        rst = 1'b1;
        #1;
        check("mid-reset stall", {31'd0, stall}, 32'd0);
        check("mid-reset ex_valid", {31'd0, ex_valid}, 32'd0);
        check("mid-reset ex_dest", {27'd0, ex_dest}, 32'd0);
        check("mid-reset ex_rs_data", ex_rs_data, 32'd0);
        check("mid-reset ex_mem_read", {31'd0, ex_mem_read}, 32'd0);
        check("mid-reset stall_count", stall_count, 32'd0);
        tick();
        check("held-reset ex_valid", {31'd0, ex_valid}, 32'd0);
        rst = 1'b0;

        // Back-to-back loads: lw r8, lw r9 <- r8, add <- r9: one stall per pair, then one more.
        loadR8();
        setId(1'b1, 5'd8, 5'd9, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 4'h0,
              32'h200, 32'h0, 32'h0);
        #1;
        check("b2b first stall", {31'd0, stall}, 32'd1);
        tick();
        check("b2b first bubble", {31'd0, ex_valid}, 32'd0);
        tick();
        check("b2b lw2 ex_dest", {27'd0, ex_dest}, 32'd9);
        setId(1'b1, 5'd9, 5'd5, 5'd11, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'h2,
              32'h0, 32'h0, 32'h0);
        #1;
        check("b2b second stall", {31'd0, stall}, 32'd1);
        tick();
        tick();
        check("b2b add ex_dest", {27'd0, ex_dest}, 32'd11);
        check("stall_count two after reset", stall_count, CntEn ? 32'd2 : 32'd0);
        loadR8();
        addFromR8();
        tick();
        tick();
        check("stall_count three", stall_count, CntEn ? 32'd3 : 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/id_ex_stage_reg.md
ID_EX_STAGE_REG -- requirements
Module: id_ex_stage_reg

Interface
REQ-001 SHALL have parameter DATA_W, default 32, operand/immediate datapath width.
REQ-002 SHALL have clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have id_valid  input  1  ID holds a real instruction.
REQ-005 SHALL have id_rs, id_rt, id_rd  input  5 each  decoded register numbers.
REQ-006 SHALL have id_rs_data, id_rt_data, id_imm  input  DATA_W each  register-file reads and sign-extended immediate.
REQ-007 SHALL have id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg, id_alu_src, id_reg_dst  input  1 each  decoded controls.
REQ-008 SHALL have id_alu_op  input  4  ALU operation code.
REQ-009 SHALL have id_uses_rt  input  1  instruction reads rt as a source (R-type, store, branch).
REQ-010 SHALL have flush  input  1  branch/jump taken; kill instruction in ID.
REQ-011 SHALL have stall  output  1  hold PC and IF/ID register this cycle.
REQ-012 SHALL have ex_valid  output  1  EX-stage instruction is real.
REQ-013 SHALL have ID_EX_RegisterRs, ID_EX_RegisterRt  output  5 each  source register numbers to the forwarding unit.
REQ-014 SHALL have ex_dest  output  5  EX destination (id_rd if reg_dst else id_rt), registered.
REQ-015 SHALL have ex_rs_data, ex_rt_data, ex_imm  output  DATA_W each  registered operands.
REQ-016 SHALL have ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_alu_src  output  1 each; ex_alu_op output 4; registered controls.
REQ-017 SHALL have stall_count  output  32  load-use stall counter (see Configuration).

Function
REQ-018 SHALL detect load-use hazard combinationally: ex_valid and ex_mem_read and ex_dest!=0 and id_valid and (ex_dest==id_rs, or id_uses_rt and ex_dest==id_rt).
REQ-019 SHALL assert stall equal to hazard and not flush; flush has priority.
REQ-020 SHALL on each edge capture: bubble if flush, or stall, or not id_valid; else all ID fields.
REQ-021 Bubble SHALL set ex_valid, ex_reg_write, ex_mem_read, ex_mem_write to 0 and ID_EX_RegisterRs/Rt and ex_dest to 0; datapath fields to 0.
REQ-022 SHALL gate ex_reg_write, ex_mem_read, ex_mem_write with ex_valid so no bubble ever writes state.
REQ-023 Latency SHALL be exactly one cycle ID to EX; no internal buffering beyond one stage.
REQ-024 Load-use stall SHALL last exactly one cycle: next cycle EX holds the bubble, hazard clears, instruction advances.
REQ-025 Back-to-back loads with dependent consumer SHALL stall once per dependent pair.
REQ-026 Register 0 SHALL never cause a stall, regardless of controls.

Reset
REQ-027 While rst high SHALL drive all registered outputs to 0 asynchronously (EX holds a bubble), stall_count to 0; stall follows REQ-019 from reset values (0).
REQ-028 Reset asserted mid-stall SHALL drop stall and discard the held ID instruction's pending capture.

Configuration
REQ-029 Macro ID_EX_STALL_CNT_EN defined: stall_count increments by 1 each cycle stall=1, saturating at 32'hFFFF_FFFF.
REQ-030 Macro undefined: stall_count SHALL be constant 0 and no counter flops exist; all other behaviour identical.

Verification
REQ-031 lw r8 in EX (ex_mem_read=1, ex_dest=8), ID add rs=8 -> stall=1 one cycle, next EX ex_valid=0, then add enters EX with ID_EX_RegisterRs=8.
REQ-032 Same as REQ-031 with flush=1 -> stall=0, EX bubble next cycle.
REQ-033 lw r0 in EX, ID rs=0 -> stall=0, instruction advances.
REQ-034 ID sw/lw with id_uses_rt=0, rt=8 vs load dest 8 -> stall=0; with id_uses_rt=1 -> stall=1.
REQ-035 rst pulse during active stall -> all outputs 0 same cycle, stall_count 0.
REQ-036 ID_EX_STALL_CNT_EN defined, three hazard cycles -> stall_count=3; undefined -> 0.
